// File: rtl/sram_snoop_capture.sv
// Passive SRAM bus snooper: shadows a contiguous address window into a buffer,
// with atomic snapshot, dirty flags and a registered snapshot read port.
// Latency: pin to capture_strobe SETTLE+3 edges; snap_req->snap_done 1 edge;
// rd_req->rd_valid 1 edge.
// Backpressure: none. This is a passive observer; requests are always accepted.
//
// Ports:
//   clk, rstn                      system clock, async active-low reset
//   sram_data_pins/address/n_write/n_ce1   raw SRAM pins (asynchronous to clk)
//   snap_req / snap_done           copy shadow -> snapshot, completion pulse
//   rd_req / rd_index / rd_data / rd_valid   snapshot read port
//   capture_strobe / capture_index per-access acceptance pulse and index
//   dirty                          per-entry changed-since-last-snapshot flags
//   update_count                   wrapping count of accepted accesses
module sram_snoop_capture #(
  parameter int                ADDR_W     = 13,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 13'h1148,
  parameter int                DEPTH      = 6,
  parameter int                IDX_W      = 6,
  parameter int                SETTLE     = 1,
  parameter int                WRITE_ONLY = 1,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] sram_data_pins,
  input  logic [ADDR_W-1:0] sram_address,
  input  logic              sram_n_write,
  input  logic              sram_n_ce1,
  input  logic              snap_req,
  output logic              snap_done,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              capture_strobe,
  output logic [IDX_W-1:0]  capture_index,
  output logic [DEPTH-1:0]  dirty,
  output logic [CNT_W-1:0]  update_count
);

  // Window bounds computed one bit wider so BASE_ADDR+DEPTH cannot wrap.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLING = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on clk after two flops.
  // ---------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------------
  // Two-flop synchronisers on all SRAM pins.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] data_s1, data_s2;
  logic [ADDR_W-1:0] addr_s1, addr_s2;
  logic              n_we_s1, n_we_s2;
  logic              n_ce_s1, n_ce_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1 <= '0;
      data_s2 <= '0;
      addr_s1 <= '0;
      addr_s2 <= '0;
      n_we_s1 <= 1'b0;
      n_we_s2 <= 1'b0;
      n_ce_s1 <= 1'b0;
      n_ce_s2 <= 1'b0;
    end else begin
      data_s1 <= sram_data_pins;
      data_s2 <= data_s1;
      addr_s1 <= sram_address;
      addr_s2 <= addr_s1;
      n_we_s1 <= sram_n_write;
      n_we_s2 <= n_we_s1;
      n_ce_s1 <= sram_n_ce1;
      n_ce_s2 <= n_ce_s1;
    end
  end

  // ---------------------------------------------------------------------
  // Access qualification on synchronised values.
  // ---------------------------------------------------------------------
  logic [ADDR_W:0] addr_ext;
  logic            in_win;
  logic            qualify;
  logic [IDX_W-1:0] acc_idx;

  assign addr_ext = {1'b0, addr_s2};
  assign in_win   = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign qualify  = !n_ce_s2 && ((WRITE_ONLY == 0) || !n_we_s2) && in_win;
  assign acc_idx  = IDX_W'(addr_ext - WIN_LO);

  // ---------------------------------------------------------------------
  // Settle filter. stable_cnt counts the qualified stable cycles already
  // seen after the first one, so the access is accepted on qualified
  // cycle number SETTLE (counting from 0), i.e. after SETTLE+1 cycles.
  // ---------------------------------------------------------------------
  state_t            state, state_d;
  logic [ADDR_W-1:0] lat_addr, lat_addr_d;
  logic [3:0]        stable_cnt, stable_cnt_d;
  logic [3:0]        cnt_inc;
  logic              start;
  logic              accept;

  assign cnt_inc = stable_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lat_addr   <= '0;
      stable_cnt <= '0;
    end else begin
      state      <= state_d;
      lat_addr   <= lat_addr_d;
      stable_cnt <= stable_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    lat_addr_d   = lat_addr;
    stable_cnt_d = stable_cnt;
    start        = 1'b0;
    accept       = 1'b0;

    case (state)
      S_IDLE: begin
        if (qualify) start = 1'b1;
      end
      S_SETTLING: begin
        if (!qualify) begin
          state_d = S_IDLE;
        end else if (addr_s2 != lat_addr) begin
          start = 1'b1;
        end else if (cnt_inc == 4'(SETTLE)) begin
          accept  = 1'b1;
          state_d = S_DONE;
        end else begin
          stable_cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        if (!qualify) begin
          state_d = S_IDLE;
        end else if (addr_s2 != lat_addr) begin
          start = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new access (fresh qualify or address change) begins settling here;
    // with no settle requirement it is accepted immediately.
    if (start) begin
      lat_addr_d   = addr_s2;
      stable_cnt_d = '0;
      if (SETTLE == 0) begin
        accept  = 1'b1;
        state_d = S_DONE;
      end else begin
        state_d = S_SETTLING;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shadow, snapshot, dirty tracking and read port.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] shadow   [DEPTH];
  logic [DATA_W-1:0] snapshot [DEPTH];
  logic [DATA_W-1:0] rd_sel;

  // Out-of-range indices fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_index == IDX_W'(i)) rd_sel = snapshot[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow[i]   <= '0;
        snapshot[i] <= '0;
      end
      dirty          <= '0;
      capture_strobe <= 1'b0;
      capture_index  <= '0;
      update_count   <= '0;
      snap_done      <= 1'b0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
    end else begin
      capture_strobe <= accept;
      snap_done      <= snap_req;
      rd_valid       <= rd_req;

      if (rd_req) rd_data <= rd_sel;

      // Snapshot reads the shadow as it was before this edge's capture.
      if (snap_req) begin
        for (int i = 0; i < DEPTH; i++) snapshot[i] <= shadow[i];
        dirty <= '0;
      end

      if (accept) begin
        capture_index <= acc_idx;
        update_count  <= update_count + 1'b1;
      end

      // Placed after the snapshot clear so an entry captured on the
      // snapshot edge stays marked dirty.
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (acc_idx == IDX_W'(i))) begin
          shadow[i] <= data_s2;
          dirty[i]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sram_snoop_capture.md
# sram_snoop_capture

Parametrised passive SRAM bus snooper that shadows a contiguous window of game SRAM (e.g. the six high-score digits at 0x1148..0x114D) into an internal buffer. It sits between the transceiver-buffered SRAM pins and the serial command layer. It replaces hard-coded per-address captures with a configurable base, depth, settle filter and write-only/any-access mode. It also provides atomic snapshots, dirty tracking and a registered read port for the serial reply path.

## Interface
- ADDR_W, 13, SRAM address width
- DATA_W, 8, SRAM data width
- BASE_ADDR, 13'h1148, first snooped address
- DEPTH, 6, number of consecutive addresses shadowed (1..64)
- IDX_W, 6, index width; must satisfy 2^IDX_W >= DEPTH
- SETTLE, 1, extra stable cycles required before sampling (0..15)
- WRITE_ONLY, 1, 1 = capture only when n_write is low; 0 = capture any CE access
- CNT_W, 16, update counter width
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- sram_data_pins  in  DATA_W  SRAM data bus (asynchronous to clk)
- sram_address  in  ADDR_W  SRAM address bus (asynchronous)
- sram_n_write  in  1  SRAM write enable, active low (asynchronous)
- sram_n_ce1  in  1  SRAM chip enable, active low (asynchronous)
- snap_req  in  1  pulse: copy shadow buffer to snapshot buffer
- snap_done  out  1  one-cycle pulse, snapshot complete
- rd_req  in  1  pulse: read snapshot entry rd_index
- rd_index  in  IDX_W  snapshot entry to read
- rd_data  out  DATA_W  snapshot data, held until next read
- rd_valid  out  1  one-cycle pulse, rd_data updated
- capture_strobe  out  1  one-cycle pulse per accepted access
- capture_index  out  IDX_W  index of last accepted access
- dirty  out  DEPTH  per-entry changed-since-last-snapshot flags
- update_count  out  CNT_W  accepted-access counter, wraps

## Operation
- All four SRAM inputs pass through 2-flop synchronisers. All decisions use synchronised values only.
- qualify = ce & (WRITE_ONLY ? we : 1) & (BASE_ADDR <= addr < BASE_ADDR+DEPTH). Compare at ADDR_W+1 bits so the window end does not wrap. Index = addr - BASE_ADDR.
- Settle filter has states IDLE, SETTLING, DONE:
  - IDLE -> SETTLING when qualify is true. Latch the address and clear stable_cnt.
  - SETTLING: while qualify holds and the address is unchanged, stable_cnt increments. When stable_cnt == SETTLE in a qualified cycle, accept the access: write the shadow entry with the synchronised data, then go to DONE. If SETTLE=0, the access is accepted in the first qualified cycle.
  - SETTLING: loss of qualify -> IDLE. An address change while still qualified restarts SETTLING on the new address.
  - DONE: no further capture until qualify is lost (-> IDLE) or the address changes (-> SETTLING). Exactly one capture per access.
- On acceptance, in the same edge: set shadow[idx] and dirty[idx], assert capture_strobe, load capture_index, and increment update_count modulo 2^CNT_W.
- snap_req copies all DEPTH shadow entries to the snapshot in one edge and clears dirty. snap_done follows one cycle later.
- snap_req and acceptance on the same edge:
  - The snapshot gets the pre-capture shadow value.
  - The accepted entry's dirty bit ends set; all other dirty bits clear.
- rd_req: rd_data <= snapshot[rd_index] and rd_valid pulses. An rd_index >= DEPTH returns 0 and still pulses rd_valid.
- rd_req on the same edge as snap_req returns the pre-snapshot value.
- Reset (async assert, clk-synchronous deassert via internal 2-flop):
  - Clears synchronisers, shadow, snapshot, dirty, update_count, capture_index and rd_data to 0.
  - Outputs go to 0; the filter goes to IDLE.
  - Reset mid-access discards it. A still-asserted qualified access after reset counts as a new access.

## Timing
- Pin-to-synchronised latency: 2 edges.
- Acceptance occurs SETTLE+1 qualified cycles after the first synchronised qualified cycle.
- Total pin change to capture_strobe high: SETTLE+3 edges minimum.
- Accesses are missed if qualify lasts fewer than SETTLE+1 synchronised cycles.
- snap_req to snap_done: 1 cycle. The snapshot is visible to rd_req on the cycle after snap_req.
- rd_req to rd_valid/rd_data: 1 cycle. Back-to-back rd_req each cycle is supported.
- All outputs are registered.

## Test plan
- Write 0x03 to 0x1149 with CE/WE held 6 cycles (SETTLE=1) -> one capture_strobe, capture_index=1, update_count=1, dirty=6'b000010.
- Same write held for only 1 synchronised cycle -> no capture, shadow unchanged. Then, with WRITE_ONLY=1, a read access at 0x114A -> no capture.
- Write to 0x1147 and to 0x114E -> no capture (window edges). Write to 0x114D -> index 5 captured.
- Write digits 00,03,00,02,09,00 to 0x1148..0x114D, pulse snap_req, then rd_req indices 0..5 -> rd_data 00,03,00,02,09,00 and dirty=0. Then rd_index 7 -> rd_data=0.
- Acceptance of 0x1148=0x07 on the same edge as snap_req (snapshot holds 0x00) -> snapshot[0]=0x00, dirty[0]=1. The next snapshot reads 0x07.
- Set update_count to 0xFFFF via 65535 accesses (or CNT_W=4 with 15 accesses), then one more -> count wraps to 0. Assert rstn low mid-SETTLING -> all outputs 0 and no capture.
